// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a pipeline stage register with valid/ready handshake.
// When SKID=1, a second (skid) entry lets in_ready come straight from state,
// so there is no combinational path from out_ready to in_ready.
// When SKID=0, the stage is a single register and ready passes through combinationally.
// Control bits named in BUBBLE_MASK read as zero whenever the output slot is a bubble.
module pipe_stage_reg #(
    parameter int                 DATA_W      = 32,
    parameter int                 CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]  BUBBLE_MASK = '1,
    parameter int                 SKID        = 1,
    parameter int                 CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (SKID != 0) ? (state_q != TWO) : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    assign out_ctrl  = out_valid ? main_ctrl_q : (main_ctrl_q & ~BUBBLE_MASK);
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    // Next state and entry loads. The main entry is always older than the skid entry.
    // Flush only clears the valid state; the data and control registers keep their contents.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Saturating count of cycles in which the output is held back by downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // All state flops. An asynchronous reset discards held entries and any in-flight transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
